// File: rtl/inst_mem_loader.sv
// Runtime program loader: assembles a little-endian byte stream into 32-bit
// instruction words, writes them to instruction memory and releases core reset on a good checksum.
module inst_mem_loader #(
   parameter int          ADDR_WIDTH = 10,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [7:0]            byte_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   output logic                  core_rst_o,
   output logic                  done_o,
   output logic                  error_o
);

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam int unsigned MAX_WORDS = (2 ** ADDR_WIDTH) - BASE_ADDR;

   state_t                state_q;
   logic                  ready_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  coreRst_q;
   logic                  done_q;
   logic                  error_q;
   logic [7:0]            lenLo_q;
   logic [15:0]           len_q;
   logic [15:0]           wordIdx_q;
   logic [1:0]            byteIdx_q;
   logic [7:0]            csum_q;
   logic [23:0]           wordBuf_q;

   logic        accept;
   logic [15:0] lenFull;

   assign accept  = byte_valid_i & ready_q;
   assign lenFull = {byte_i, lenLo_q};

   // The 4th byte of a word goes straight into the write data, so only three bytes are buffered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         coreRst_q <= 1'b1;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         lenLo_q   <= '0;
         len_q     <= '0;
         wordIdx_q <= '0;
         byteIdx_q <= '0;
         csum_q    <= '0;
         wordBuf_q <= '0;
      end else begin
         we_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE, ERR: begin
               if (start_i) begin
                  state_q   <= LEN0;
                  ready_q   <= 1'b1;
                  coreRst_q <= 1'b1;
                  done_q    <= 1'b0;
                  error_q   <= 1'b0;
                  lenLo_q   <= '0;
                  len_q     <= '0;
                  wordIdx_q <= '0;
                  byteIdx_q <= '0;
                  csum_q    <= '0;
                  wordBuf_q <= '0;
               end
            end
            LEN0: begin
               if (accept) begin
                  lenLo_q <= byte_i;
                  state_q <= LEN1;
               end
            end
            LEN1: begin
               if (accept) begin
                  len_q <= lenFull;
                  if (32'(lenFull) > MAX_WORDS) begin
                     state_q <= ERR;
                     ready_q <= 1'b0;
                     error_q <= 1'b1;
                  end else if (lenFull == 16'd0) begin
                     state_q <= CSUM;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  csum_q    <= csum_q ^ byte_i;
                  byteIdx_q <= byteIdx_q + 2'd1;
                  if (byteIdx_q == 2'd3) begin
                     we_q      <= 1'b1;
                     addr_q    <= ADDR_WIDTH'(BASE_ADDR + 32'(wordIdx_q));
                     wdata_q   <= {byte_i, wordBuf_q};
                     wordIdx_q <= wordIdx_q + 16'd1;
                     if (wordIdx_q + 16'd1 == len_q) begin
                        state_q <= CSUM;
                     end
                  end else begin
                     wordBuf_q[8*byteIdx_q +: 8] <= byte_i;
                  end
               end
            end
            CSUM: begin
               if (accept) begin
                  ready_q <= 1'b0;
                  if (byte_i == csum_q) begin
                     state_q   <= DONE;
                     done_q    <= 1'b1;
                     coreRst_q <= 1'b0;
                  end else begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign byte_ready_o = ready_q;
   assign mem_we_o     = we_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign core_rst_o   = coreRst_q;
   assign done_o       = done_q;
   assign error_o      = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: expected memory writes are queued
// as words are streamed in and compared when mem_we_o pulses.
module tb_inst_mem_loader;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_i;
   logic [7:0] byte_i;
   logic       byte_valid_i;
   logic       byte_ready_o;
   logic       mem_we_o;
   logic [9:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic       core_rst_o;
   logic       done_o;
   logic       error_o;

   wr_t expQ[$];
   int  checks = 0;
   int  errors = 0;
   int  writeCount = 0;

   localparam logic [31:0] WORD0 = 32'h00100513;
   localparam logic [31:0] WORD1 = 32'h00200593;

   inst_mem_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .core_rst_o   (core_rst_o),
      .done_o       (done_o),
      .error_o      (error_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Every write pulse must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (mem_we_o === 1'b1) begin
         writeCount++;
         if (expQ.size() > 0) begin
            wr_t e;
            e = expQ.pop_front();
            checkOutput("wr_addr", 32'(mem_addr_o), 32'(e.addr));
            checkOutput("wr_data", mem_wdata_o, e.data);
         end else begin
            checkOutput("wr_unexpected", 32'(mem_we_o), 32'd0);
         end
      end
   end

   task automatic sendByte(input logic [7:0] b, input bit stall);
      int guard;
      bit taken;
      guard = 0;
      taken = 0;
      while (!taken && guard < 60) begin
         if (stall && $urandom_range(0, 1) == 1) begin
            byte_valid_i = 1'b0;
            byte_i       = ~b;
         end else begin
            byte_i       = b;
            byte_valid_i = 1'b1;
            taken        = byte_ready_o;
         end
         @(negedge clk);
         guard++;
      end
      if (!taken) checkOutput("byte_accept_timeout", 32'(taken), 32'd1);
   endtask

   task automatic sendWord(input logic [31:0] w, input logic [9:0] a, input bit stall, inout logic [7:0] csum);
      expQ.push_back(wr_t'{addr: a, data: w});
      for (int i = 0; i < 4; i++) begin
         sendByte(w[8*i +: 8], stall);
         csum = csum ^ w[8*i +: 8];
      end
      checkOutput("we_latency", 32'(mem_we_o), 32'd1);
   endtask

   task automatic pulseStart();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic applyStimulus(input bit stall, input bit badCsum);
      logic [7:0] csum;
      csum = 8'h00;
      pulseStart();
      checkOutput("ready_after_start", 32'(byte_ready_o), 32'd1);
      sendByte(8'h02, stall);
      sendByte(8'h00, stall);
      sendWord(WORD0, 10'd0, stall, csum);
      sendWord(WORD1, 10'd1, stall, csum);
      sendByte(badCsum ? 8'h00 : csum, stall);
      byte_valid_i = 1'b0;
   endtask

   initial begin
      int wc;
      rst          = 1'b1;
      start_i      = 1'b0;
      byte_i       = 8'h00;
      byte_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_core_rst", 32'(core_rst_o), 32'd1);
      checkOutput("rst_ready", 32'(byte_ready_o), 32'd0);
      checkOutput("rst_done", 32'(done_o), 32'd0);
      checkOutput("rst_error", 32'(error_o), 32'd0);
      checkOutput("rst_we", 32'(mem_we_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] basic load");
      wc = writeCount;
      applyStimulus(0, 0);
      checkOutput("basic_done", 32'(done_o), 32'd1);
      checkOutput("basic_core_rst", 32'(core_rst_o), 32'd0);
      checkOutput("basic_error", 32'(error_o), 32'd0);
      checkOutput("basic_ready", 32'(byte_ready_o), 32'd0);
      checkOutput("basic_writes", 32'(writeCount - wc), 32'd2);
      checkOutput("basic_queue", 32'(expQ.size()), 32'd0);

      $display("[TB] bad checksum");
      wc = writeCount;
      applyStimulus(0, 1);
      checkOutput("badcs_error", 32'(error_o), 32'd1);
      checkOutput("badcs_core_rst", 32'(core_rst_o), 32'd1);
      checkOutput("badcs_done", 32'(done_o), 32'd0);
      checkOutput("badcs_writes", 32'(writeCount - wc), 32'd2);

      $display("[TB] zero length");
      wc = writeCount;
      pulseStart();
      checkOutput("zero_error_cleared", 32'(error_o), 32'd0);
      sendByte(8'h00, 0);
      sendByte(8'h00, 0);
      sendByte(8'h00, 0);
      byte_valid_i = 1'b0;
      checkOutput("zero_done", 32'(done_o), 32'd1);
      checkOutput("zero_core_rst", 32'(core_rst_o), 32'd0);
      checkOutput("zero_writes", 32'(writeCount - wc), 32'd0);

      $display("[TB] oversize length");
      wc = writeCount;
      pulseStart();
      sendByte(8'h01, 0);
      sendByte(8'h04, 0);
      byte_valid_i = 1'b0;
      checkOutput("over_error", 32'(error_o), 32'd1);
      checkOutput("over_ready", 32'(byte_ready_o), 32'd0);
      checkOutput("over_core_rst", 32'(core_rst_o), 32'd1);
      byte_valid_i = 1'b1;
      repeat (4) @(negedge clk);
      byte_valid_i = 1'b0;
      checkOutput("over_writes", 32'(writeCount - wc), 32'd0);

      $display("[TB] stalled load");
      wc = writeCount;
      applyStimulus(1, 0);
      checkOutput("stall_done", 32'(done_o), 32'd1);
      checkOutput("stall_core_rst", 32'(core_rst_o), 32'd0);
      checkOutput("stall_writes", 32'(writeCount - wc), 32'd2);

      $display("[TB] restart then reset mid-load");
      pulseStart();
      checkOutput("restart_done", 32'(done_o), 32'd0);
      checkOutput("restart_core_rst", 32'(core_rst_o), 32'd1);
      begin
         logic [7:0] cs;
         cs = 8'h00;
         wc = writeCount;
         sendByte(8'h02, 0);
         sendByte(8'h00, 0);
         sendWord(WORD0, 10'd0, 0, cs);
         sendByte(WORD1[7:0], 0);
         sendByte(WORD1[15:8], 0);
      end
      rst          = 1'b1;
      byte_valid_i = 1'b0;
      @(negedge clk);
      checkOutput("midrst_core_rst", 32'(core_rst_o), 32'd1);
      checkOutput("midrst_ready", 32'(byte_ready_o), 32'd0);
      checkOutput("midrst_we", 32'(mem_we_o), 32'd0);
      checkOutput("midrst_addr", 32'(mem_addr_o), 32'd0);
      checkOutput("midrst_wdata", mem_wdata_o, 32'd0);
      checkOutput("midrst_done", 32'(done_o), 32'd0);
      checkOutput("midrst_error", 32'(error_o), 32'd0);
      repeat (2) @(negedge clk);
      rst          = 1'b0;
      byte_valid_i = 1'b1;
      repeat (3) @(negedge clk);
      byte_valid_i = 1'b0;
      checkOutput("midrst_writes", 32'(writeCount - wc), 32'd1);
      checkOutput("midrst_idle_ready", 32'(byte_ready_o), 32'd0);
      checkOutput("final_queue", 32'(expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
